lsu_mem_if: RTL and testbench
=============================

Name: lsu_mem_if

Overview:
- Load/store initiator between the CPU's memory stage and the SRAM data port (port 2).
- Accepts one byte, halfword or word request at a time and checks alignment and range.
- Drives the SRAM's active-low chip select, write enable, byte enables and steered write data.
- Captures read data one cycle after the SRAM clock edge and returns it sign- or zero-extended with a single-cycle response pulse.

Parameters:
- ADDR_W, 12: SRAM word-address width; byte window is 2^(ADDR_W+2) bytes.
- BASE_ADDR, 32'h0000_0000: byte base of the SRAM window; must be aligned to the window size.

Ports:
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend the load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_err  out  1  fault flag, qualified by rsp_valid
- rsp_rdata  out  32  load result; 0 for stores and faults
- MEM_CSN  out  1  SRAM chip select, active low
- MEM_ADDR  out  ADDR_W  SRAM word address
- MEM_WE  out  1  1 = write
- MEM_BE  out  4  byte-lane enables
- MEM_DI  out  32  SRAM write data
- MEM_DO  in  32  SRAM read data, valid the cycle after the access edge

Behaviour:
- Clock and reset: one clock, CLK. RESET_N is asynchronous, active low.
- Reset values:
  - MEM_CSN=1, MEM_WE=0, MEM_BE=0, MEM_ADDR=0, MEM_DI=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - State IDLE, so req_ready=1.
- FSM states: IDLE, ACCESS, CAPTURE, RESP. req_ready=1 only in IDLE.
- Accept: a request is taken on a rising edge with req_valid&&req_ready. Address, size, signedness and offset are registered at that edge.
- Fault check at accept, in priority order:
  - req_size=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]
  - On fault: go directly to RESP with rsp_err=1 and rsp_rdata=0. MEM_CSN is never asserted.
- ACCESS (one cycle): MEM_CSN=0 and MEM_ADDR=req_addr[ADDR_W+1:2].
  - Store: MEM_WE=1.
    - Byte: MEM_BE=1<<addr[1:0], MEM_DI={4{wdata[7:0]}}.
    - Half: MEM_BE = addr[1] ? 1100 : 0011, MEM_DI={2{wdata[15:0]}}.
    - Word: MEM_BE=1111, MEM_DI=wdata.
    - Next state is RESP.
  - Load: MEM_WE=0 and MEM_BE=1111 for every load size, so all DO lanes refresh and no stale lane is used. Next state is CAPTURE.
- CAPTURE: MEM_CSN=1. Select the lane from MEM_DO by the registered offset, extend per req_signed, register into rsp_rdata. Next state is RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Outside ACCESS: MEM_CSN=1, MEM_WE=0, MEM_BE=0. MEM_ADDR and MEM_DI hold their last values.
- Latency from the accept edge to rsp_valid high:
  - fault: 1 cycle
  - store: 2 cycles
  - load: 3 cycles
- Back-to-back requests: the next request is accepted no earlier than the edge that enters IDLE after RESP. A req_valid held high is simply stalled.
- rsp_err and rsp_rdata are cleared at the start of each new request. They hold their value between responses.
- Reset mid-operation:
  - MEM_CSN goes high and MEM_BE clears immediately (asynchronously).
  - The in-flight request is dropped and no rsp_valid is issued.
  - A store whose ACCESS edge has not occurred does not write.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - the FSM state enum
  - the BE pattern constants
- One combinational sub-module, lsu_load_extend: inputs MEM_DO, offset, size, signed; output is the 32-bit result.
- Store-lane steering stays inline in lsu_mem_if.

Test Plan:
All scenarios use ADDR_W=12 and BASE_ADDR=0.
1. Store word at 0x40, data 0x8899AABB
   - One cycle after accept: MEM_CSN=0, MEM_WE=1, MEM_ADDR=0x010, MEM_BE=1111, MEM_DI=0x8899AABB.
   - rsp_valid 2 cycles after accept, rsp_err=0.
2. After scenario 1, signed byte load at 0x43
   - ACCESS shows MEM_BE=1111.
   - rsp_rdata=0xFFFFFF88 3 cycles after accept.
   - Same load unsigned gives 0x00000088.
   - Signed half load at 0x40 gives 0xFFFFAABB.
3. Store half at 0x42, data 0x00001234, then word load at 0x40
   - Store: MEM_BE=1100, MEM_DI=0x12341234.
   - Load: rsp_rdata=0x1234AABB.
4. Fault requests: word at 0x41; half at 0x43; req_size=11 at 0x40; word at 0x4000
   - Each: MEM_CSN stays 1, rsp_valid 1 cycle after accept, rsp_err=1, rsp_rdata=0.
5. Assert RESET_N=0 during the ACCESS of a word store of 0xDEADBEEF to 0x80
   - MEM_CSN=1 immediately and no rsp_valid.
   - After release: req_ready=1, and a load at 0x80 returns the pre-reset contents, not 0xDEADBEEF.
6. Hold req_valid=1 across two loads
   - req_ready=0 in ACCESS, CAPTURE and RESP.
   - Second accept lands on the edge after RESP.
   - Exactly two rsp_valid pulses, spaced 4 cycles apart.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// SRAM byte-enable patterns.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  localparam logic [3:0] BE_NONE  = 4'b0000;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_LO    = 4'b0011;
  localparam logic [3:0] BE_HI    = 4'b1100;
  localparam logic [3:0] BE_ALL   = 4'b1111;

endpackage

// File: rtl/lsu_load_extend.sv
// Picks the addressed byte/halfword out of a full SRAM read word and
// sign- or zero-extends it to 32 bits.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] mem_do,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = mem_do[7:0];
    case (offset)
      2'd1:    lane_b = mem_do[15:8];
      2'd2:    lane_b = mem_do[23:16];
      2'd3:    lane_b = mem_do[31:24];
      default: lane_b = mem_do[7:0];
    endcase
    lane_h = offset[1] ? mem_do[31:16] : mem_do[15:0];

    result = mem_do;
    case (size)
      SZ_BYTE: result = {{24{sign_ext & lane_b[7]}}, lane_b};
      SZ_HALF: result = {{16{sign_ext & lane_h[15]}}, lane_h};
      default: result = mem_do;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store initiator: checks one request at a time, runs a single SRAM
// access on port 2 and returns a one-cycle response.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              MEM_CSN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DO
);

  lsu_state_t  state, state_next;
  logic        accept, fault;
  logic        write_q, signed_q;
  logic [1:0]  size_q, offset_q;
  logic [3:0]  store_be;
  logic [31:0] store_di, load_result;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    fault = 1'b0;
    if (req_size == SZ_ILL)
      fault = 1'b1;
    else if (req_size == SZ_HALF && req_addr[0])
      fault = 1'b1;
    else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
      fault = 1'b1;
    else if (req_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2])
      fault = 1'b1;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    store_be = BE_ALL;
    store_di = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        store_be = BE_BYTE0 << req_addr[1:0];
        store_di = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        store_be = req_addr[1] ? BE_HI : BE_LO;
        store_di = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = fault ? RESP : ACCESS;
      ACCESS:  state_next = write_q ? RESP : CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  lsu_load_extend u_load_extend (
    .mem_do   (MEM_DO),
    .offset   (offset_q),
    .size     (size_q),
    .sign_ext (signed_q),
    .result   (load_result)
  );

  // SRAM strobes are registered so reset deasserts them immediately.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      MEM_CSN   <= 1'b1;
      MEM_WE    <= 1'b0;
      MEM_BE    <= BE_NONE;
      MEM_ADDR  <= '0;
      MEM_DI    <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      write_q   <= 1'b0;
      signed_q  <= 1'b0;
      size_q    <= SZ_BYTE;
      offset_q  <= 2'b00;
    end else begin
      MEM_CSN <= 1'b1;
      MEM_WE  <= 1'b0;
      MEM_BE  <= BE_NONE;
      if (accept) begin
        rsp_err   <= fault;
        rsp_rdata <= '0;
        write_q   <= req_write;
        signed_q  <= req_signed;
        size_q    <= req_size;
        offset_q  <= req_addr[1:0];
        if (!fault) begin
          MEM_CSN  <= 1'b0;
          MEM_ADDR <= req_addr[ADDR_W+1:2];
          MEM_WE   <= req_write;
          if (req_write) begin
            MEM_BE <= store_be;
            MEM_DI <= store_di;
          end else begin
            MEM_BE <= BE_ALL;
          end
        end
      end
      if (state == CAPTURE)
        rsp_rdata <= load_result;
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if with a behavioural SRAM and a response
// scoreboard keyed on the expected response cycle.
module tb_lsu_mem_if;

  localparam int ADDR_W = 12;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              req_valid, req_ready, req_write, req_signed;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic              MEM_CSN, MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [3:0]        MEM_BE;
  logic [31:0]       MEM_DI, MEM_DO;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [31:0] sram [0:(1<<ADDR_W)-1];

  lsu_mem_if #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0000_0000)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .MEM_CSN    (MEM_CSN),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WE     (MEM_WE),
    .MEM_BE     (MEM_BE),
    .MEM_DI     (MEM_DI),
    .MEM_DO     (MEM_DO)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Synchronous SRAM: byte-masked write, read data registered one cycle later.
  always @(posedge CLK) begin
    if (MEM_CSN === 1'b0) begin
      if (MEM_WE === 1'b1)
        for (int i = 0; i < 4; i++)
          if (MEM_BE[i]) sram[MEM_ADDR][i*8 +: 8] <= MEM_DI[i*8 +: 8];
      MEM_DO <= sram[MEM_ADDR];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic send(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic e_err, input logic [31:0] e_rd, input int lat);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    check("accept_wait", {31'b0, n < 20}, 32'd1);
    sb.push_back('{e_err, e_rd, cyc + lat});
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || req_ready !== 1'b1) && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    check("drain_wait", {31'b0, n < 20}, 32'd1);
  endtask

  task automatic check_access(input logic we, input logic [ADDR_W-1:0] a,
                              input logic [3:0] be, input logic [31:0] di, input bit chk_di);
    check("acc_csn", {31'b0, MEM_CSN}, 32'd0);
    check("acc_we", {31'b0, MEM_WE}, {31'b0, we});
    check("acc_addr", {20'b0, MEM_ADDR}, {20'b0, a});
    check("acc_be", {28'b0, MEM_BE}, {28'b0, be});
    if (chk_di) check("acc_di", MEM_DI, di);
  endtask

  initial begin
    logic [1:0]  fsz [4];
    logic [31:0] fadr [4];
    fsz  = '{W, H, X, W};
    fadr = '{32'h41, 32'h43, 32'h40, 32'h4000};

    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0;
    repeat (2) @(posedge CLK);
    #1;
    $display("[TB] reset state");
    check("rst_csn", {31'b0, MEM_CSN}, 32'd1);
    check("rst_we", {31'b0, MEM_WE}, 32'd0);
    check("rst_be", {28'b0, MEM_BE}, 32'd0);
    check("rst_addr", {20'b0, MEM_ADDR}, 32'd0);
    check("rst_di", MEM_DI, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    $display("[TB] preload");
    send(1, W, 0, 32'h80, 32'h1122_3344, 0, 32'h0, 2); drain();
    send(1, W, 0, 32'h3FFC, 32'hCAFE_F00D, 0, 32'h0, 2);
    check_access(1, 12'hFFF, 4'hF, 32'hCAFE_F00D, 1); drain();

    $display("[TB] word store / sized loads");
    send(1, W, 0, 32'h40, 32'h8899_AABB, 0, 32'h0, 2);
    check_access(1, 12'h010, 4'b1111, 32'h8899_AABB, 1); drain();
    send(0, B, 1, 32'h43, 32'h0, 0, 32'hFFFF_FF88, 3);
    check_access(0, 12'h010, 4'b1111, 32'h0, 0); drain();
    send(0, B, 0, 32'h43, 32'h0, 0, 32'h0000_0088, 3); drain();
    send(0, H, 1, 32'h40, 32'h0, 0, 32'hFFFF_AABB, 3); drain();

    $display("[TB] half/byte stores");
    send(1, H, 0, 32'h42, 32'h0000_1234, 0, 32'h0, 2);
    check_access(1, 12'h010, 4'b1100, 32'h1234_1234, 1); drain();
    send(0, W, 0, 32'h40, 32'h0, 0, 32'h1234_AABB, 3); drain();
    send(1, B, 0, 32'h41, 32'h0000_005A, 0, 32'h0, 2);
    check_access(1, 12'h010, 4'b0010, 32'h5A5A_5A5A, 1); drain();
    send(0, W, 0, 32'h40, 32'h0, 0, 32'h1234_5ABB, 3); drain();
    send(0, B, 1, 32'h42, 32'h0, 0, 32'h0000_0034, 3); drain();
    send(0, H, 0, 32'h42, 32'h0, 0, 32'h0000_1234, 3); drain();
    send(0, W, 0, 32'h3FFC, 32'h0, 0, 32'hCAFE_F00D, 3); drain();

    $display("[TB] faults");
    for (int i = 0; i < 4; i++) begin
      send(0, fsz[i], 0, fadr[i], 32'h0, 1, 32'h0, 1);
      check("fault_csn", {31'b0, MEM_CSN}, 32'd1);
      drain();
    end

    $display("[TB] reset during store access");
    send(1, W, 0, 32'h80, 32'hDEAD_BEEF, 0, 32'h0, 2);
    check("s5_csn_access", {31'b0, MEM_CSN}, 32'd0);
    RESET_N = 1'b0;
    #1;
    check("s5_csn_reset", {31'b0, MEM_CSN}, 32'd1);
    check("s5_be_reset", {28'b0, MEM_BE}, 32'd0);
    sb.delete();
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    check("s5_ready", {31'b0, req_ready}, 32'd1);
    @(posedge CLK); #1;
    send(0, W, 0, 32'h80, 32'h0, 0, 32'h1122_3344, 3); drain();

    $display("[TB] held req_valid");
    req_valid = 1'b1; req_write = 1'b0; req_size = W; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h0;
    check("s6_ready_first", {31'b0, req_ready}, 32'd1);
    sb.push_back('{1'b0, 32'h1234_5ABB, cyc + 3});
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("s6_ready_busy", {31'b0, req_ready}, 32'd0);
    end
    @(posedge CLK); #1;
    check("s6_ready_idle", {31'b0, req_ready}, 32'd1);
    sb.push_back('{1'b0, 32'h1234_5ABB, cyc + 3});
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("s6_ready_second", {31'b0, req_ready}, 32'd0);
    drain();

    repeat (4) @(posedge CLK);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
